// File: rtl/dvi_tmds_encoder.sv
`timescale 1ns/1ps
// Three-channel DVI 1.0 TMDS encoder: 8b/10b transition-minimised, DC-balanced
// symbols with a fixed two-cycle pipeline (q_m stage, then symbol/disparity stage).
module dvi_tmds_encoder #(
    parameter bit INVERT_SYNC = 1'b0
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [23:0] rgb_pixel,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2
);

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    function automatic logic [3:0] count_ones(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, d[i]};
        return n;
    endfunction

    function automatic logic [8:0] transition_min(input logic [7:0] d);
        logic [3:0] n;
        logic       use_xnor;
        logic [8:0] q;
        n        = count_ones(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] control_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = TOKEN_00;
            2'b01:   t = TOKEN_01;
            2'b10:   t = TOKEN_10;
            default: t = TOKEN_11;
        endcase
        return t;
    endfunction

    // Shared stage-1 timing: ctl_s1 = {c1, c0} for channel 0 only.
    logic       de_s1;
    logic [1:0] ctl_s1;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            de_s1  <= 1'b0;
            ctl_s1 <= 2'b00;
        end else begin
            de_s1  <= de;
            ctl_s1 <= {vsync ^ INVERT_SYNC, hsync ^ INVERT_SYNC};
        end
    end

    for (genvar g = 0; g < 3; g++) begin : chan
        logic [8:0]        qm_d;
        logic [8:0]        qm_s1;
        logic [3:0]        n1_s1;
        logic [1:0]        ctl;
        logic signed [4:0] diff;
        logic signed [4:0] cnt_q;
        logic signed [4:0] cnt_d;
        logic [9:0]        sym_d;
        logic [9:0]        sym_q;

        assign qm_d = transition_min(rgb_pixel[8*g +: 8]);
        assign ctl  = (g == 0) ? ctl_s1 : 2'b00;

        always_ff @(posedge clk_pixel or negedge rst_n) begin
            if (!rst_n) begin
                qm_s1 <= 9'd0;
                n1_s1 <= 4'd0;
            end else begin
                qm_s1 <= qm_d;
                n1_s1 <= count_ones(qm_d[7:0]);
            end
        end

        // diff = N1 - N0 of q_m[7:0], i.e. 2*N1 - 8 in signed 5-bit.
        always_comb begin
            diff  = $signed({n1_s1, 1'b0} - 5'd8);
            sym_d = TOKEN_00;
            cnt_d = 5'sd0;
            if (!de_s1) begin
                sym_d = control_token(ctl);
                cnt_d = 5'sd0;
            end else if ((cnt_q == 5'sd0) || (n1_s1 == 4'd4)) begin
                sym_d = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
                cnt_d = qm_s1[8] ? (cnt_q + diff) : (cnt_q - diff);
            end else if (((cnt_q > 5'sd0) && (n1_s1 > 4'd4)) ||
                         ((cnt_q < 5'sd0) && (n1_s1 < 4'd4))) begin
                sym_d = {1'b1, qm_s1[8], ~qm_s1[7:0]};
                cnt_d = qm_s1[8] ? (cnt_q + 5'sd2 - diff) : (cnt_q - diff);
            end else begin
                sym_d = {1'b0, qm_s1[8], qm_s1[7:0]};
                cnt_d = qm_s1[8] ? (cnt_q + diff) : (cnt_q - 5'sd2 + diff);
            end
        end

        always_ff @(posedge clk_pixel or negedge rst_n) begin
            if (!rst_n) begin
                sym_q <= TOKEN_00;
                cnt_q <= 5'sd0;
            end else begin
                sym_q <= sym_d;
                cnt_q <= cnt_d;
            end
        end
    end

    assign tmds_ch0 = chan[0].sym_q;
    assign tmds_ch1 = chan[1].sym_q;
    assign tmds_ch2 = chan[2].sym_q;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
`timescale 1ns/1ps
// Bench for dvi_tmds_encoder: directed token/disparity/reset cases plus a long
// random run, all scored against an integer reference model of DVI 1.0 TMDS.
module tb_dvi_tmds_encoder;

    localparam bit INV = 1'b0;
    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] Z_ACT = 10'b0100000000;

    logic        clk_pixel = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] rgb_pixel = 24'd0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        de = 1'b0;
    logic [9:0]  tmds_ch0;
    logic [9:0]  tmds_ch1;
    logic [9:0]  tmds_ch2;

    dvi_tmds_encoder #(.INVERT_SYNC(INV)) dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .rgb_pixel (rgb_pixel),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .tmds_ch0  (tmds_ch0),
        .tmds_ch1  (tmds_ch1),
        .tmds_ch2  (tmds_ch2)
    );

    always #20 clk_pixel = ~clk_pixel;

    int          checks = 0;
    int          errors = 0;
    logic [29:0] exp_q[$];
    bit          drv_valid = 1'b0;
    int          mcnt[3] = '{0, 0, 0};

    task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // q_m bit i is the parity of d[0..i]; the XNOR chain additionally flips odd bits.
    function automatic logic [9:0] ref_sym(input logic [7:0] d, input bit act, input bit c1,
                                           input bit c0, input int cnt_in, output int cnt_out);
        int         ones, n1, n0;
        bit         xnor_path;
        logic [7:0] m;
        logic [8:0] qm;
        logic [9:0] sym;
        cnt_out = 0;
        if (!act) begin
            case ({c1, c0})
                2'b00:   sym = T00;
                2'b01:   sym = T01;
                2'b10:   sym = T10;
                default: sym = T11;
            endcase
            return sym;
        end
        ones      = $countones(d);
        xnor_path = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        for (int i = 0; i < 8; i++) begin
            m     = 8'hFF >> (7 - i);
            qm[i] = (^(d & m)) ^ (xnor_path && (i % 2 == 1));
        end
        qm[8] = !xnor_path;
        n1    = $countones(qm[7:0]);
        n0    = 8 - n1;
        if (cnt_in == 0 || n1 == n0) begin
            if (qm[8]) begin
                sym = {2'b01, qm[7:0]};
                cnt_out = cnt_in + n1 - n0;
            end else begin
                sym = {2'b10, ~qm[7:0]};
                cnt_out = cnt_in + n0 - n1;
            end
        end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            cnt_out = cnt_in + (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            cnt_out = cnt_in - (qm[8] ? 0 : 2) + n1 - n0;
        end
        return sym;
    endfunction

    task automatic send(input logic [23:0] rgb, input bit d, input bit h, input bit v,
                        input bit ovr_en, input logic [29:0] ovr);
        logic [9:0] s[3];
        int         nc;
        @(negedge clk_pixel);
        rgb_pixel = rgb;
        de        = d;
        hsync     = h;
        vsync     = v;
        drv_valid = 1'b1;
        for (int ch = 0; ch < 3; ch++) begin
            s[ch] = ref_sym(rgb[8*ch +: 8], d, (ch == 0) ? (v ^ INV) : 1'b0,
                            (ch == 0) ? (h ^ INV) : 1'b0, mcnt[ch], nc);
            mcnt[ch] = nc;
        end
        exp_q.push_back(ovr_en ? ovr : {s[2], s[1], s[0]});
    endtask

    task automatic mid_reset();
        @(negedge clk_pixel);
        #10;
        rst_n = 1'b0;
        #1;
        check("reset_midstream", {tmds_ch2, tmds_ch1, tmds_ch0}, {3{T00}});
        exp_q.delete();
        drv_valid = 1'b0;
        de        = 1'b0;
        hsync     = 1'b0;
        vsync     = 1'b0;
        for (int ch = 0; ch < 3; ch++) mcnt[ch] = 0;
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        rst_n = 1'b1;
        @(posedge clk_pixel);
        #6;
        check("post_release", {tmds_ch2, tmds_ch1, tmds_ch0}, {3{T00}});
    endtask

    // Monitor: a slot issued at a negedge appears after the second following rising edge.
    initial begin : monitor
        bit v1, v2;
        v1 = 1'b0;
        v2 = 1'b0;
        forever begin
            @(posedge clk_pixel);
            if (!rst_n) begin
                v1 = 1'b0;
                v2 = 1'b0;
            end else begin
                v2 = v1;
                v1 = drv_valid;
            end
            #5;
            if (v2 && rst_n) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sym: got %b required <no queued entry>",
                             {tmds_ch2, tmds_ch1, tmds_ch0});
                end else begin
                    check("sym", {tmds_ch2, tmds_ch1, tmds_ch0}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stimulus
        bit de_r;
        rgb_pixel = 24'($urandom);
        de        = 1'b1;
        hsync     = 1'b1;
        vsync     = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", {tmds_ch2, tmds_ch1, tmds_ch0}, {3{T00}});
        de    = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        repeat (3) @(negedge clk_pixel);
        rst_n = 1'b1;
        @(posedge clk_pixel);
        #6;
        check("post_release", {tmds_ch2, tmds_ch1, tmds_ch0}, {3{T00}});
        repeat (4) send(24'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, {3{T00}});

        // Sync tokens on channel 0
        send(24'($urandom), 1'b0, 1'b1, 1'b0, 1'b1, {T00, T00, T01});
        send(24'($urandom), 1'b0, 1'b1, 1'b1, 1'b1, {T00, T00, T11});
        send(24'($urandom), 1'b0, 1'b0, 1'b1, 1'b1, {T00, T00, T10});
        send(24'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, {3{T00}});

        // Disparity run on black, then clear on one blanking slot
        send(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, {3{Z_ACT}});
        send(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, {3{10'b1111111111}});
        send(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, {3{Z_ACT}});
        send(24'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, {3{T00}});
        send(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, {3{Z_ACT}});

        // XNOR path and XOR path with all-ones q_m
        send(24'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, {3{T00}});
        send(24'h0000FF, 1'b1, 1'b0, 1'b0, 1'b1, {Z_ACT, Z_ACT, 10'b1000000000});
        send(24'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, {3{T00}});
        send(24'h000001, 1'b1, 1'b0, 1'b0, 1'b1, {Z_ACT, Z_ACT, 10'b0111111111});
        repeat (6) send(24'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 30'd0);

        mid_reset();
        send(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, {3{Z_ACT}});

        de_r = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(15) == 0) de_r = ~de_r;
            send(24'($urandom), de_r, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 30'd0);
            if (i == 5000) begin
                mid_reset();
                send(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, {3{Z_ACT}});
            end
        end

        @(negedge clk_pixel);
        drv_valid = 1'b0;
        repeat (4) @(negedge clk_pixel);
        check("drain", 30'(exp_q.size()), 30'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
